// File: rtl/matrix_print_tx_if.sv
// Bundle of the control, storage-read and transmit signals of matrix_print_tx.
// slave is the printer itself; master is whatever drives it (FSM, memory, UART).
interface matrix_print_tx_if;
  logic        en_output;
  logic        start;
  logic [8:0]  base_addr;
  logic [2:0]  dim_m;
  logic [2:0]  dim_n;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  en_output, start, base_addr, dim_m, dim_n, rd_data, tx_ready,
    output rd_addr, tx_data, tx_valid, busy, done, err
  );

  modport master (
    output en_output, start, base_addr, dim_m, dim_n, rd_data, tx_ready,
    input  rd_addr, tx_data, tx_valid, busy, done, err
  );
endinterface

// File: rtl/matrix_print_tx.sv
// Prints an m x n matrix of 16-bit unsigned values from storage as ASCII
// decimal text: elements separated by a space, every row ended by CR LF.
module matrix_print_tx (
  input  logic               clk,
  input  logic               rst_n,
  matrix_print_tx_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE, CHECK, RD_ADDR, RD_WAIT, CONVERT,
    SEND_DIGIT, SEND_SP, SEND_CR, SEND_LF, DONE
  } state_t;

  state_t           r_state;
  logic [2:0]       r_m, r_n;      // sampled dimensions
  logic [2:0]       r_i, r_j;      // current row / column
  logic [15:0]      r_val;         // value being converted
  logic [4:0][3:0]  r_dig;         // low-order digits, index 0 = units
  logic [2:0]       r_nd;          // digits produced so far
  logic [2:0]       r_idx;         // low-order digits still to send
  logic [8:0]       r_rd_addr;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_xfer;
  logic [15:0]      w_quo;
  logic [3:0]       w_rem;
  logic             w_illegal;

  assign w_xfer    = r_tx_valid & bus.tx_ready;
  // one decimal digit per CONVERT cycle: at most 5 cycles for 65535
  assign w_quo     = r_val / 16'd10;
  assign w_rem     = 4'(r_val % 16'd10);
  assign w_illegal = (bus.dim_m == 3'd0) || (bus.dim_m > 3'd5) ||
                     (bus.dim_n == 3'd0) || (bus.dim_n > 3'd5);

  // Control FSM with all outputs registered. Elements are row-major and
  // contiguous, so the read address simply increments after each element.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_m        <= '0;
      r_n        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_val      <= '0;
      r_dig      <= '0;
      r_nd       <= '0;
      r_idx      <= '0;
      r_rd_addr  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (!bus.en_output) begin
      // abandon the print; a pending byte is dropped, never transferred
      r_state    <= IDLE;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (bus.start && !r_busy) begin
            r_m       <= bus.dim_m;
            r_n       <= bus.dim_n;
            r_i       <= '0;
            r_j       <= '0;
            r_rd_addr <= bus.base_addr;
            r_busy    <= 1'b1;
            // err is visible during CHECK so it coincides with busy
            r_err     <= w_illegal;
            r_state   <= CHECK;
          end
        end
        CHECK: begin
          if (r_err) begin
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= RD_ADDR;
          end
        end
        RD_ADDR: r_state <= RD_WAIT;
        RD_WAIT: begin
          r_val   <= bus.rd_data[15:0];
          r_nd    <= '0;
          r_state <= CONVERT;
        end
        CONVERT: begin
          r_dig[r_nd] <= w_rem;
          r_val       <= w_quo;
          r_nd        <= r_nd + 3'd1;
          if (r_val < 16'd10) begin
            // remainder is now the most significant digit
            r_tx_data  <= 8'h30 + {4'h0, w_rem};
            r_tx_valid <= 1'b1;
            r_idx      <= r_nd;
            r_state    <= SEND_DIGIT;
          end
        end
        SEND_DIGIT: begin
          if (w_xfer) begin
            if (r_idx == 3'd0) begin
              if (r_j == r_n - 3'd1) begin
                r_tx_data <= 8'h0D;
                r_state   <= SEND_CR;
              end else begin
                r_tx_data <= 8'h20;
                r_state   <= SEND_SP;
              end
            end else begin
              r_tx_data <= 8'h30 + {4'h0, r_dig[r_idx - 3'd1]};
              r_idx     <= r_idx - 3'd1;
            end
          end
        end
        SEND_SP: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_j        <= r_j + 3'd1;
            r_rd_addr  <= r_rd_addr + 9'd1;
            r_state    <= RD_ADDR;
          end
        end
        SEND_CR: begin
          if (w_xfer) begin
            r_tx_data <= 8'h0A;
            r_state   <= SEND_LF;
          end
        end
        SEND_LF: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            if (r_i == r_m - 3'd1) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_i       <= r_i + 3'd1;
              r_j       <= '0;
              r_rd_addr <= r_rd_addr + 9'd1;
              r_state   <= RD_ADDR;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rd_addr  = r_rd_addr;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_matrix_print_tx.sv
// Scoreboard bench for matrix_print_tx: the model turns memory contents into
// the expected text with $sformatf, a monitor pops and compares each byte.
module tb_matrix_print_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matrix_print_tx_if bus();
  matrix_print_tx dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [512];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];
  int busy_cnt = 0, done_cnt = 0, err_cnt = 0, byte_cnt = 0;
  bit xfer_flag = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data = '0;
  int stall_mode = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // expected text of a print, straight from the formatting rules
  function automatic void model(input logic [8:0] b, input logic [2:0] m, input logic [2:0] n);
    string s;
    int a;
    if (m == 0 || m > 5 || n == 0 || n > 5) return;
    for (int i = 0; i < int'(m); i++)
      for (int j = 0; j < int'(n); j++) begin
        a = (int'(b) + i * int'(n) + j) % 512;
        s = $sformatf("%0d", mem[a][15:0]);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(8'(s[k]));
        if (j == int'(n) - 1) begin
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
        end else exp_q.push_back(8'h20);
      end
  endfunction

  // monitor: samples on the falling edge what the next rising edge will do
  always @(negedge clk) begin
    bit xfer;
    xfer = 0;
    if (rst_n) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.err)  err_cnt++;
      if (prev_stall && bus.tx_valid && bus.en_output)
        chk("tx_hold", {24'h0, bus.tx_data}, {24'h0, prev_data});
      xfer = bus.tx_valid && bus.tx_ready && bus.en_output;
      if (xfer) begin
        byte_cnt++;
        if (exp_q.size() == 0) chk("tx_extra", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
      end
      prev_stall = bus.tx_valid && !bus.tx_ready && bus.en_output;
      prev_data  = bus.tx_data;
    end else prev_stall = 0;
    xfer_flag = xfer;
  end

  // tx_ready: always high, or low 0..10 cycles before each byte
  initial begin
    int cnt;
    cnt = 0;
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_mode == 0) bus.tx_ready = 1'b1;
      else begin
        if (xfer_flag) cnt = $urandom_range(0, 10);
        if (cnt > 0) begin bus.tx_ready = 1'b0; cnt--; end
        else bus.tx_ready = 1'b1;
      end
    end
  end

  task automatic pulse_start(input logic [8:0] b, input logic [2:0] m, input logic [2:0] n);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = b; bus.dim_m = m; bus.dim_n = n;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.base_addr = 9'($urandom); bus.dim_m = 3'($urandom); bus.dim_n = 3'($urandom);
  endtask

  task automatic run(input logic [8:0] b, input logic [2:0] m, input logic [2:0] n);
    int d0, e0, bc0, bu0;
    bit legal, hit;
    d0 = done_cnt; e0 = err_cnt; bc0 = byte_cnt; bu0 = busy_cnt;
    legal = !(m == 0 || m > 5 || n == 0 || n > 5);
    model(b, m, n);
    pulse_start(b, m, n);
    hit = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (done_cnt != d0 || err_cnt != e0) begin hit = 1; break; end
    end
    chk("end_timeout", {31'h0, hit}, 32'h1);
    repeat (2) @(negedge clk);
    if (legal) begin
      chk("done_pulses", done_cnt - d0, 1);
      chk("no_err", err_cnt - e0, 0);
      chk("q_empty", exp_q.size(), 0);
      chk("busy_after", {31'h0, bus.busy}, 0);
    end else begin
      chk("err_pulses", err_cnt - e0, 1);
      chk("err_busy_cycles", busy_cnt - bu0, 1);
      chk("err_bytes", byte_cnt - bc0, 0);
      chk("err_no_done", done_cnt - d0, 0);
    end
    exp_q.delete();
  endtask

  task automatic rand_mem;
    logic [31:0] v;
    for (int a = 0; a < 512; a++) begin
      v = $urandom;
      case ($urandom_range(0, 3))
        0: v[15:0] = 16'h0;
        1: v[15:0] = 16'($urandom_range(0, 9));
        2: v[15:0] = 16'($urandom_range(0, 999));
        default: ;
      endcase
      mem[a] = v;
    end
  endtask

  initial begin
    int bc, d0, bu;
    bit hit;
    rand_mem();
    bus.en_output = 1'b1; bus.start = 1'b1;
    bus.base_addr = 9'd0; bus.dim_m = 3'd2; bus.dim_n = 3'd2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_addr", {23'h0, bus.rd_addr}, 0);
    chk("rst_tx_data", {24'h0, bus.tx_data}, 0);
    chk("rst_ctl", {28'h0, bus.tx_valid, bus.busy, bus.done, bus.err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_in_reset_ignored", {31'h0, bus.busy}, 0);

    // 2x3, values 1..6
    for (int a = 0; a < 6; a++) mem[a] = 32'(a + 1);
    run(9'd0, 3'd2, 3'd3);
    // zero, multi-digit, maximum; upper half ignored
    mem[20] = 32'd0; mem[21] = 32'd100; mem[22] = 32'hABCD_FFFF;
    run(9'd20, 3'd1, 3'd3);
    mem[30] = 32'h0001_0007;
    run(9'd30, 3'd1, 3'd1);
    // illegal dimensions
    run(9'd0, 3'd0, 3'd3);
    run(9'd0, 3'd2, 3'd6);
    run(9'd0, 3'd7, 3'd1);
    // same 2x3 print under random back-pressure
    stall_mode = 1;
    run(9'd0, 3'd2, 3'd3);
    stall_mode = 0;

    // wrap past the top of storage
    mem[510] = 32'd12345; mem[511] = 32'd7; mem[0] = 32'd999;
    run(9'd510, 3'd1, 3'd3);

    // en_output dropped mid-row
    d0 = done_cnt;
    model(9'd510, 3'd1, 3'd3);
    pulse_start(9'd510, 3'd1, 3'd3);
    bc = byte_cnt; hit = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (byte_cnt - bc >= 4) begin hit = 1; break; end
    end
    chk("abort_progress", {31'h0, hit}, 1);
    @(posedge clk); #1;
    bus.en_output = 1'b0;
    @(posedge clk); #1;
    chk("abort_tx_valid", {31'h0, bus.tx_valid}, 0);
    chk("abort_busy", {31'h0, bus.busy}, 0);
    bc = byte_cnt;
    repeat (10) @(negedge clk);
    chk("abort_no_bytes", byte_cnt - bc, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    exp_q.delete();
    @(posedge clk); #1;
    bus.en_output = 1'b1;
    run(9'd510, 3'd1, 3'd3);

    // reset mid-print
    d0 = done_cnt;
    model(9'd100, 3'd5, 3'd5);
    pulse_start(9'd100, 3'd5, 3'd5);
    bc = byte_cnt;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (byte_cnt - bc >= 4) break;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    bc = byte_cnt; bu = busy_cnt;
    repeat (20) @(negedge clk);
    chk("reset_abort_bytes", byte_cnt - bc, 0);
    chk("reset_abort_busy", busy_cnt - bu, 0);
    chk("reset_abort_done", done_cnt - d0, 0);
    exp_q.delete();

    // random prints, random dims including illegal ones
    for (int t = 0; t < 12; t++) begin
      rand_mem();
      stall_mode = $urandom_range(0, 1);
      run(9'($urandom), 3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)));
    end
    stall_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
